// File: rtl/jk_pkg.sv
// Shared types for the JK-cell count sequencer: opcodes, FSM states and
// J/K excitation encodings.
package jk_pkg;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'b00,
      OP_UP     = 2'b01,
      OP_DOWN   = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_e;

   typedef struct packed {
      logic j;
      logic k;
   } jk_t;

   localparam jk_t JK_HOLD = jk_t'{j: 1'b0, k: 1'b0};
   localparam jk_t JK_SET  = jk_t'{j: 1'b1, k: 1'b0};
   localparam jk_t JK_CLR  = jk_t'{j: 1'b0, k: 1'b1};
   localparam jk_t JK_TGL  = jk_t'{j: 1'b1, k: 1'b1};

   // Minimal excitation moving one cell from cur to nxt.
   function automatic jk_t excite(input logic cur, input logic nxt);
      if (cur == nxt) return JK_HOLD;
      return nxt ? JK_SET : JK_CLR;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Behavioural JK flip-flop with asynchronous active-high clear.
module jk_cell (
   input  logic clk,
   input  logic cl,
   input  logic j_i,
   input  logic k_i,
   output logic q_o
);

   always_ff @(posedge clk or posedge cl) begin
      if (cl) begin
         q_o <= 1'b0;
      end else begin
         case ({j_i, k_i})
            2'b01:   q_o <= 1'b0;
            2'b10:   q_o <= 1'b1;
            2'b11:   q_o <= ~q_o;
            default: q_o <= q_o;
         endcase
      end
   end

endmodule

// File: rtl/jk_count_sequencer.sv
// Command-driven sequencer that drives J/K excitation into a bank of JK cells
// to load, count up/down by N steps, or toggle under a mask.
import jk_pkg::*;

module jk_count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             cl,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   state_e           state_q;
   op_e              op_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] cnt_q;
   logic             done_q;
   logic             tc_q;

   logic             is_run;
   logic             last_step;
   logic             step_d;
   logic             finish_d;
   logic             tc_d;
   logic             run_ones;
   logic             run_zeros;
   logic [WIDTH-1:0] tgl_d;
   jk_t              jk_d [WIDTH];

   always_comb begin
      is_run    = (op_q == OP_UP) || (op_q == OP_DOWN);
      last_step = (cnt_q == WIDTH'(1));
      // Abort only suppresses a step that is not the final one.
      step_d    = (state_q == S_EXEC) &&
                  (!is_run || ((cnt_q != '0) && (!abort || last_step)));
      finish_d  = (state_q == S_EXEC) &&
                  (!is_run || (cnt_q == '0) || last_step || abort);
      tc_d      = step_d && (((op_q == OP_UP) && (&q)) ||
                             ((op_q == OP_DOWN) && (~|q)));

      tgl_d     = '0;
      run_ones  = 1'b1;
      run_zeros = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tgl_d[i]  = (op_q == OP_UP) ? run_ones : run_zeros;
         run_ones  = run_ones & q[i];
         run_zeros = run_zeros & ~q[i];
      end

      for (int i = 0; i < WIDTH; i++) begin
         jk_d[i] = JK_HOLD;
         if (step_d) begin
            case (op_q)
               OP_LOAD:   jk_d[i] = data_q[i] ? JK_SET : JK_CLR;
               OP_TOGGLE: jk_d[i] = data_q[i] ? JK_TGL : JK_HOLD;
               default:   jk_d[i] = tgl_d[i] ? JK_TGL : JK_HOLD;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge cl) begin
      if (cl) begin
         state_q <= S_IDLE;
         op_q    <= OP_LOAD;
         data_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         tc_q   <= tc_d;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  state_q <= S_EXEC;
                  op_q    <= op_e'(cmd_op);
                  data_q  <= cmd_data;
                  cnt_q   <= cmd_data;
               end
            end
            S_EXEC: begin
               if (step_d && is_run) cnt_q <= cnt_q - WIDTH'(1);
               if (finish_d) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
         .clk (clk),
         .cl  (cl),
         .j_i (jk_d[gi].j),
         .k_i (jk_d[gi].k),
         .q_o (q[gi])
      );
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q == S_EXEC);
   assign done      = done_q;
   assign tc        = tc_q;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Bench for jk_count_sequencer: directed scenarios then random commands,
// each checked against an arithmetic model of the register value.
module tb_jk_count_sequencer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         cl;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;
   logic         abort;
   logic [W-1:0] q;
   logic         busy;
   logic         done;
   logic         tc;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];
   logic         exp_tc[$];
   logic [W-1:0] q_m;

   always #5 clk = ~clk;

   jk_count_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .cl        (cl),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .abort     (abort),
      .q         (q),
      .busy      (busy),
      .done      (done),
      .tc        (tc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command from an IDLE negedge; abort_at=k raises abort before edge Ek.
   task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data,
                         input int abort_at, input bit hold_valid);
      int           n_edges;
      int           n_steps;
      int           t;
      logic [W-1:0] m;
      logic [W-1:0] e_q;
      logic         e_tc;

      if (op == 2'd0 || op == 2'd3 || data == 0) n_edges = 1;
      else if (abort_at > 0 && abort_at < int'(data)) n_edges = abort_at;
      else n_edges = int'(data);
      n_steps = (op == 2'd1 || op == 2'd2) && abort_at > 0 && abort_at < int'(data)
                ? abort_at - 1 : int'(data);

      m = q_m;
      for (int k = 1; k <= n_edges; k++) begin
         e_tc = 1'b0;
         case (op)
            2'd0: m = data;
            2'd3: m = m ^ data;
            2'd1: if (k <= n_steps) begin e_tc = (m == 4'hF); m = m + 4'd1; end
            default: if (k <= n_steps) begin e_tc = (m == 4'h0); m = m - 4'd1; end
         endcase
         exp_q.push_back(m);
         exp_tc.push_back(e_tc);
      end

      t = 0;
      while (!cmd_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ready_before_cmd", cmd_ready, 1'b1);

      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      @(negedge clk);
      if (hold_valid) cmd_data = ~data;
      else cmd_valid = 1'b0;
      check("accept_busy", busy, 1'b1);
      check("accept_ready", cmd_ready, 1'b0);
      check("accept_done", done, 1'b0);

      for (int k = 1; k <= n_edges; k++) begin
         abort = (k == abort_at);
         @(posedge clk);
         @(negedge clk);
         abort = 1'b0;
         e_q  = exp_q.pop_front();
         e_tc = exp_tc.pop_front();
         check("step_q", q, e_q);
         check("step_tc", tc, e_tc);
         check("step_done", done, k == n_edges);
         check("step_busy", busy, k != n_edges);
      end
      cmd_valid = 1'b0;
      q_m = m;
   endtask

   initial begin
      cl        = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_data  = '0;
      abort     = 1'b0;
      q_m       = '0;

      // 1: reset state, then LOAD 0xA
      @(negedge clk);
      check("rst_q", q, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_tc", tc, 1'b0);
      check("rst_ready", cmd_ready, 1'b1);
      @(negedge clk);
      cl = 1'b0;
      @(negedge clk);
      do_cmd(2'd0, 4'hA, 0, 1'b0);

      // 2: UP 3 through the all-ones wrap
      do_cmd(2'd0, 4'hE, 0, 1'b0);
      do_cmd(2'd1, 4'd3, 0, 1'b0);

      // 3: DOWN 2 through zero
      do_cmd(2'd2, 4'd2, 0, 1'b0);

      // 4: TOGGLE mask, then UP N=0 no-op
      do_cmd(2'd0, 4'hF, 0, 1'b0);
      do_cmd(2'd3, 4'h5, 0, 1'b0);
      do_cmd(2'd1, 4'd0, 0, 1'b0);

      // 5: abort at E4 with cmd_valid held during EXEC
      do_cmd(2'd0, 4'h3, 0, 1'b0);
      do_cmd(2'd1, 4'd10, 4, 1'b1);
      check("abort_q", q, 4'h6);
      @(posedge clk);
      @(negedge clk);
      check("idle_after_abort_busy", busy, 1'b0);
      check("idle_after_abort_done", done, 1'b0);

      // abort on the final step edge still completes the step
      do_cmd(2'd1, 4'd2, 2, 1'b0);

      // abort in IDLE is ignored
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_busy", busy, 1'b0);
      check("idle_abort_done", done, 1'b0);
      check("idle_abort_q", q, q_m);

      // 6: clear mid-run of UP 8
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_data  = 4'd8;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("midrun_q", q, q_m + 4'd3);
      cl = 1'b1;
      #1;
      check("clr_q", q, 4'h0);
      check("clr_busy", busy, 1'b0);
      check("clr_ready", cmd_ready, 1'b1);
      check("clr_done", done, 1'b0);
      @(negedge clk);
      cl  = 1'b0;
      q_m = '0;
      @(posedge clk);
      @(negedge clk);
      check("post_clr_done", done, 1'b0);
      check("post_clr_busy", busy, 1'b0);
      do_cmd(2'd0, 4'h5, 0, 1'b0);

      // random commands
      for (int r = 0; r < 60; r++) begin
         logic [1:0]   op;
         logic [W-1:0] d;
         int           ab;
         op = 2'($urandom_range(0, 3));
         d  = W'($urandom_range(0, 15));
         ab = 0;
         if ((op == 2'd1 || op == 2'd2) && $urandom_range(0, 1) == 1)
            ab = $urandom_range(1, 16);
         do_cmd(op, d, ab, $urandom_range(0, 3) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
